// File: rtl/gray_pkg.sv
//------------------------------------------------------------------------------
// Module   : gray_pkg
// Purpose  : Shared width default and Gray-code helpers for gray_code_counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gray_pkg;

    localparam int unsigned DEFAULT_WIDTH = 3;

    // Helpers work on 32-bit containers; callers zero-extend and truncate.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2gray_comb.sv
//------------------------------------------------------------------------------
// Module   : bin2gray_comb
// Purpose  : Purely combinational binary-to-Gray encoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bin2gray_comb
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = WIDTH'(bin2gray(32'(bin_i)));

endmodule

`default_nettype wire

// File: rtl/gray_code_counter.sv
//------------------------------------------------------------------------------
// Module   : gray_code_counter
// Purpose  : Up/down binary counter with registered Gray image and terminal
//            count. Define GRAY_CHECK_EN to add the sticky single-bit-step
//            checker driving err; otherwise err is tied low.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_code_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             err
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             tc_q;
    logic             tc_d;
    logic             count_step;

    assign count_step = en && !load;

    always_comb begin
        bin_d = bin_q;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            bin_d = up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
        end
    end

    // Encode the next-state count so bin and gray land in the same register stage.
    bin2gray_comb #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin_i  (bin_d),
        .gray_o (gray_d)
    );

    assign tc_d = up ? (bin_d == {WIDTH{1'b1}}) : (bin_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

`ifdef GRAY_CHECK_EN
    logic err_q;

    // gray_q is the previous code word; only counting edges must be single-bit steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (count_step && (popcount(32'(gray_d ^ gray_q)) != 1)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_count_step;
    assign unused_count_step = count_step;
    assign err = 1'b0;
`endif

    assign bin  = bin_q;
    assign gray = gray_q;
    assign tc   = tc_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_code_counter.sv
//------------------------------------------------------------------------------
// Module   : tb_gray_code_counter
// Purpose  : Scoreboard bench for gray_code_counter with a reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gray_code_counter;

    localparam int WIDTH = 3;
    localparam int MODV  = 1 << WIDTH;

    typedef struct {
        int bin;
        int gray;
        int tc;
        int err;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             tc;
    logic             err;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int   m_bin;
    int   m_tc;

    gray_code_counter #(
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .bin      (bin),
        .gray     (gray),
        .tc       (tc),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and push the state the counter must show after the edge.
    task automatic step(input bit r, input bit e, input bit u, input bit l, input int lb);
        exp_t x;
        @(negedge clk);
        rst      = r;
        en       = e;
        up       = u;
        load     = l;
        load_bin = WIDTH'(lb);
        if (r) begin
            m_bin = 0;
            m_tc  = 0;
        end else begin
            if (l)      m_bin = lb % MODV;
            else if (e) m_bin = u ? (m_bin + 1) % MODV : (m_bin + MODV - 1) % MODV;
            m_tc = u ? int'(m_bin == MODV - 1) : int'(m_bin == 0);
        end
        x.bin  = m_bin;
        x.gray = m_bin ^ (m_bin / 2);
        x.tc   = r ? 0 : m_tc;
        x.err  = 0;
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: the counter presents a new state after every edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                check("bin",  int'(bin),  x.bin);
                check("gray", int'(gray), x.gray);
                check("tc",   int'(tc),   x.tc);
                check("err",  int'(err),  x.err);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_bin = 0;
        m_tc  = 0;
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = '0;

        // Reset wins over en and load.
        repeat (2) step(1, 1, 1, 1, 5);
        // Full up sweep with wrap.
        repeat (8) step(0, 1, 1, 0, 0);
        // Down from 0 through the wrap.
        repeat (3) step(0, 1, 0, 0, 0);
        // Load beats simultaneous enable, then count up.
        step(0, 1, 1, 1, 5);
        step(0, 1, 1, 0, 0);
        // Hold, then reset mid-count at 011.
        repeat (3) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 3);
        step(1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        // Direction change alone must update tc.
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        // Full down sweep.
        repeat (9) step(0, 1, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1, ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, MODV - 1)));
        end
        step(0, 0, 1, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        check("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
